// File: rtl/div128_by64.sv
// Sequential restoring divider: 128-bit dividend / 64-bit divisor, one quotient bit per cycle.
// valid/ready handshake on both sides; divide-by-zero returns all-ones quotient and the low dividend bits.
//
// state | meaning
// IDLE  | in_ready high, waiting for operands
// RUN   | shifting one quotient bit per cycle, PD_WIDTH cycles
// DONE  | result registered, held until out_ready
module div128_by64 #(
    parameter int                  P_WIDTH  = 64,
    parameter int                  PD_WIDTH = 128,
    parameter logic [PD_WIDTH-1:0] PD_ZERO  = '0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [PD_WIDTH-1:0] A_in,
    input  logic [P_WIDTH-1:0]  B_in,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [PD_WIDTH-1:0] Q_out,
    output logic [P_WIDTH-1:0]  R_out,
    output logic                div_zero
);
    localparam int CW = $clog2(PD_WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                state_q, state_d;
    logic [P_WIDTH-1:0]    d_q, d_d;
    logic [PD_WIDTH-1:0]   q_q, q_d;
    logic [P_WIDTH-1:0]    r_q, r_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  out_valid_q, out_valid_d;
    logic [PD_WIDTH-1:0]   q_out_q, q_out_d;
    logic [P_WIDTH-1:0]    r_out_q, r_out_d;
    logic                  div_zero_q, div_zero_d;

    logic [P_WIDTH:0]      s;
    logic                  ge;
    logic [PD_WIDTH-1:0]   q_nxt;
    logic [P_WIDTH-1:0]    r_nxt;

    assign in_ready  = (state_q == IDLE);
    assign out_valid = out_valid_q;
    assign Q_out     = q_out_q;
    assign R_out     = r_out_q;
    assign div_zero  = div_zero_q;

    // The partial remainder is always < d, so only its low P_WIDTH bits are stored;
    // the shifted value s carries the extra bit for the compare/subtract.
    always_comb begin
        s     = {r_q, q_q[PD_WIDTH-1]};
        ge    = (s >= {1'b0, d_q});
        q_nxt = {q_q[PD_WIDTH-2:0], ge};
        r_nxt = P_WIDTH'(ge ? (s - {1'b0, d_q}) : s);
    end

    always_comb begin
        state_d     = state_q;
        d_d         = d_q;
        q_d         = q_q;
        r_d         = r_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        q_out_d     = q_out_q;
        r_out_d     = r_out_q;
        div_zero_d  = div_zero_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    d_d   = B_in;
                    q_d   = A_in;
                    r_d   = '0;
                    cnt_d = CW'(PD_WIDTH - 1);
                    if (B_in == '0) begin
                        q_out_d    = '1;
                        r_out_d    = A_in[P_WIDTH-1:0];
                        div_zero_d = 1'b1;
                        state_d    = DONE;
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                q_d   = q_nxt;
                r_d   = r_nxt;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    q_out_d     = q_nxt;
                    r_out_d     = r_nxt;
                    div_zero_d  = 1'b0;
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end
            end
            DONE: begin
                // Divide-by-zero enters DONE with out_valid low; it rises one cycle after accept.
                if (!out_valid_q) begin
                    out_valid_d = 1'b1;
                end else if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            d_q         <= '0;
            q_q         <= PD_ZERO;
            r_q         <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            q_out_q     <= PD_ZERO;
            r_out_q     <= '0;
            div_zero_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            d_q         <= d_d;
            q_q         <= q_d;
            r_q         <= r_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            q_out_q     <= q_out_d;
            r_out_q     <= r_out_d;
            div_zero_q  <= div_zero_d;
        end
    end
endmodule

// File: tb/tb_div128_by64.sv
// Scoreboard bench for div128_by64: directed corner cases, backpressure, mid-run reset, random operands.
module tb_div128_by64;
    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] a_in;
    logic [63:0]  b_in;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] q_out;
    logic [63:0]  r_out;
    logic         div_zero;

    typedef struct packed {
        logic [127:0] a;
        logic [63:0]  b;
    } op_t;

    op_t exp_q[$];
    op_t mon_op;
    int  n_checks = 0;
    int  n_pass   = 0;
    int  n_in     = 0;
    int  n_out    = 0;

    div128_by64 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A_in      (a_in),
        .B_in      (b_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Q_out     (q_out),
        .R_out     (r_out),
        .div_zero  (div_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk_eq(input string tag, input logic [191:0] obs, input logic [191:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    function automatic logic [63:0] rand64();
        return {$urandom, $urandom};
    endfunction

    // Outputs are stable at the falling edge; a handshake seen here completes on the next rising edge.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk_eq("unexpected_result", 192'd1, 192'd0);
            end else begin
                mon_op = exp_q.pop_front();
                if (mon_op.b == 64'd0) begin
                    chk_eq("q_div0", q_out, {128{1'b1}});
                    chk_eq("r_div0", r_out, mon_op.a[63:0]);
                    chk_eq("dz_flag", div_zero, 1'b1);
                end else begin
                    chk_eq("q", q_out, mon_op.a / {64'd0, mon_op.b});
                    chk_eq("r", r_out, mon_op.a % {64'd0, mon_op.b});
                    chk_eq("dz_flag", div_zero, 1'b0);
                    chk_eq("q_b_plus_r", {64'd0, q_out} * {128'd0, mon_op.b} + {128'd0, r_out},
                           {64'd0, mon_op.a});
                    chk_eq("r_lt_b", r_out < mon_op.b, 1'b1);
                end
            end
            n_out++;
        end
    end

    // Returns at the sample point just after the accept edge.
    task automatic start_op(input logic [127:0] a, input logic [63:0] b);
        int n;
        in_valid = 1'b1;
        a_in     = a;
        b_in     = b;
        n = 0;
        while (!in_ready && n < 400) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) chk_eq("accept_timeout", 192'd0, 192'd1);
        exp_q.push_back('{a: a, b: b});
        n_in++;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic finish_op(input string tag, input bit rnd_ready, input int exp_lat);
        int cyc;
        int lat;
        int rdy_bad;
        cyc = 0;
        lat = -1;
        rdy_bad = 0;
        while (n_out < n_in && cyc < 3000) begin
            if (out_valid && lat < 0) lat = cyc;
            if (in_ready) rdy_bad++;
            a_in      = {rand64(), rand64()};
            b_in      = rand64();
            out_ready = rnd_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
            @(posedge clk); #1;
            cyc++;
        end
        out_ready = 1'b0;
        chk_eq({tag, "_done"}, n_out, n_in);
        chk_eq({tag, "_in_ready_low"}, rdy_bad, 0);
        if (exp_lat >= 0) chk_eq({tag, "_latency"}, lat, exp_lat);
    endtask

    task automatic run_op(input string tag, input logic [127:0] a, input logic [63:0] b,
                          input bit rnd_ready, input int exp_lat);
        start_op(a, b);
        finish_op(tag, rnd_ready, exp_lat);
    endtask

    initial begin
        logic [127:0] ra;
        logic [63:0]  rb;
        int           bad;
        int           n;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a_in      = '0;
        b_in      = '0;
        #1;
        chk_eq("rst_out_valid", out_valid, 1'b0);
        chk_eq("rst_q_out", q_out, 128'd0);
        chk_eq("rst_r_out", r_out, 64'd0);
        chk_eq("rst_div_zero", div_zero, 1'b0);
        chk_eq("rst_in_ready", in_ready, 1'b1);
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        run_op("d100_7", 128'd100, 64'd7, 1'b0, 128);
        run_op("dmax", {128{1'b1}}, {64{1'b1}}, 1'b0, 128);
        run_op("d1234_1", 128'h1234, 64'd1, 1'b0, 128);
        run_op("d5_9", 128'd5, 64'd9, 1'b0, 128);
        run_op("div0", {64'h0123_4567_89AB_CDEF, 64'hDEAD_BEEF_CAFE_F00D}, 64'd0, 1'b0, 1);

        // Backpressure: result must hold and in_valid pulses must be ignored.
        start_op(128'd77777, 64'd10);
        n = 0;
        while (!out_valid && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        chk_eq("bp_out_valid_rise", out_valid, 1'b1);
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            in_valid = i[0];
            a_in     = {rand64(), rand64()};
            b_in     = rand64();
            @(posedge clk); #1;
            if (!out_valid || q_out !== 128'd7777 || r_out !== 64'd7 || in_ready) bad++;
        end
        chk_eq("bp_stable", bad, 0);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk_eq("bp_release_out_valid", out_valid, 1'b0);
        chk_eq("bp_release_in_ready", in_ready, 1'b1);
        chk_eq("bp_result_taken", n_out, n_in);

        // Reset 60 cycles into RUN discards the operation.
        start_op({1'b1, 127'd12345}, 64'd987654321);
        repeat (60) begin
            @(posedge clk); #1;
        end
        #2 rst_n = 1'b0;
        #1;
        chk_eq("mid_rst_out_valid", out_valid, 1'b0);
        chk_eq("mid_rst_q_out", q_out, 128'd0);
        chk_eq("mid_rst_r_out", r_out, 64'd0);
        chk_eq("mid_rst_div_zero", div_zero, 1'b0);
        chk_eq("mid_rst_in_ready", in_ready, 1'b1);
        exp_q.delete();
        n_in = n_out;
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        run_op("d1000_3", 128'd1000, 64'd3, 1'b0, 128);

        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 9))
                0, 1: begin rb = {64{1'b1}}; ra = {rand64(), rand64()}; end
                2, 3: begin rb = rand64() | 64'd1; ra = {64'd0, rand64() % rb}; end
                4:    begin rb = 64'($urandom_range(1, 255)); ra = {rand64(), rand64()}; end
                5:    begin rb = 64'd0; ra = {rand64(), rand64()}; end
                default: begin rb = rand64() | 64'd1; ra = {rand64(), rand64()}; end
            endcase
            run_op("rand", ra, rb, 1'b1, -1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
